kmeans_ctrl: RTL
================

KMEANS_CTRL -- requirements
Module: kmeans_ctrl

Interface
REQ-001 Parameters SHALL be: PW, default 16, point-address/count width; IW, default 8, iteration-count width.
REQ-002 Ports SHALL be (name direction width meaning), with clock and reset first:
- clk  in  1  sole clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a clustering run; sampled only in IDLE
- abort  in  1  synchronous cancel of a run in progress
- num_points  in  PW  number of points in point memory; latched on start
- max_iter  in  IW  iteration limit; latched on start
- converged  in  1  centroid comparator result; sampled only in LOAD
- pt_addr  out  PW  point-memory read address
- pt_rd  out  1  point-memory read strobe; data returns 1 cycle later
- acc_rst  out  1  synchronous clear for the accumulator
- acc  out  1  accumulate the point currently on the memory data bus
- swap  out  1  latch divided sums into new_centroids
- cent_load  out  1  copy new_centroids into the active centroid register
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at normal run completion
- conv_flag  out  1  last run ended by convergence
- iter_count  out  IW  completed iterations of current or last run

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, CLEAR, STREAM, DRAIN, SWAP, LOAD, DONE.
REQ-004 In IDLE with start=1: if num_points=0 or max_iter=0, the FSM SHALL go to DONE with iter_count=0 and conv_flag=0; otherwise it SHALL latch num_points and max_iter, clear iter_count and conv_flag, and go to CLEAR.
REQ-005 CLEAR SHALL assert acc_rst for one cycle, zero the address counter, and go to STREAM.
REQ-006 STREAM SHALL assert pt_rd with pt_addr = address counter and increment the counter each cycle; after the cycle with pt_addr = num_points-1 it SHALL go to DRAIN.
REQ-007 acc SHALL equal pt_rd delayed by one cycle, so acc is asserted for exactly num_points consecutive cycles per iteration, with the last one in DRAIN.
REQ-008 DRAIN SHALL last one cycle, with pt_rd=0, and then go to SWAP.
REQ-009 SWAP SHALL assert swap for one cycle and then go to LOAD.
REQ-010 LOAD SHALL assert cent_load for one cycle and increment iter_count.
REQ-011 From LOAD, the FSM SHALL go to DONE if converged=1 (setting conv_flag=1) or if the incremented iter_count equals max_iter; otherwise it SHALL go to CLEAR.
REQ-012 DONE SHALL assert done for one cycle and then go to IDLE.
REQ-013 Each iteration SHALL take num_points+4 cycles; done SHALL be asserted exactly 1 + I*(num_points+4) cycles after the start cycle, where I is the number of iterations executed.
REQ-014 start SHALL be ignored while busy=1; num_points and max_iter changes after latching SHALL have no effect.
REQ-015 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with all strobes low and no done pulse; iter_count SHALL hold its value.
REQ-016 abort and start together in IDLE: start SHALL be honoured, because abort has no effect in IDLE.
REQ-017 acc_rst, acc, swap and cent_load SHALL each be asserted only in their designated state or cycle and SHALL be mutually exclusive.
REQ-018 The address counter SHALL never exceed num_points-1; pt_addr SHALL hold 0 outside STREAM.
REQ-019 iter_count SHALL be unsigned modulo 2^IW; max_iter = 2^IW-1 SHALL be supported without wrap before termination.

Reset
REQ-020 rst=1 SHALL immediately and asynchronously force state IDLE and all outputs to 0: pt_addr=0, pt_rd=0, acc_rst=0, acc=0, swap=0, cent_load=0, busy=0, done=0, conv_flag=0, iter_count=0.
REQ-021 rst asserted mid-run SHALL discard the run with no done pulse; after rst deasserts, the first rising edge SHALL evaluate from IDLE.

Verification
REQ-022 num_points=4, max_iter=3, converged=0 -> acc high 4 cycles per iteration, 3 swap and 3 cent_load pulses, done 25 cycles after start, iter_count=3, conv_flag=0.
REQ-023 num_points=5, max_iter=10, converged=1 in the second LOAD -> done 19 cycles after start, iter_count=2, conv_flag=1.
REQ-024 num_points=0, or max_iter=0 -> next cycle DONE, done pulse 1 cycle after start, no pt_rd/acc/swap pulses, iter_count=0.
REQ-025 abort during STREAM at pt_addr=2 (num_points=8) -> next cycle IDLE, busy=0, no done pulse, all strobes 0; a new start then runs normally.
REQ-026 rst during SWAP -> outputs 0 asynchronously, before the next clock edge; start pulses while busy in another run are ignored and do not alter timing.
REQ-027 num_points=1, max_iter=1 -> pt_rd 1 cycle at address 0, acc 1 cycle in DRAIN, done 6 cycles after start.

Source files
------------

// File: rtl/kmeans_ctrl.sv
// kmeans_ctrl: sequences point streaming, accumulation, centroid swap/load and iteration control for k-means
module kmeans_ctrl #(
    parameter int PW = 16,
    parameter int IW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [PW-1:0] num_points,
    input  logic [IW-1:0] max_iter,
    input  logic          converged,
    output logic [PW-1:0] pt_addr,
    output logic          pt_rd,
    output logic          acc_rst,
    output logic          acc,
    output logic          swap,
    output logic          cent_load,
    output logic          busy,
    output logic          done,
    output logic          conv_flag,
    output logic [IW-1:0] iter_count
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] STREAM = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] SWAP   = 3'd4;
    localparam logic [2:0] LOAD   = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;
    logic [2:0]    state_q, state_d;
    logic [PW-1:0] addr_q, addr_d, np_q, np_d;
    logic [IW-1:0] mi_q, mi_d, iter_q, iter_d;
    logic          conv_q, conv_d, acc_q;
    // next-state logic; abort outranks everything once a run is in progress
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        np_d    = np_q;
        mi_d    = mi_q;
        iter_d  = iter_q;
        conv_d  = conv_q;
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            addr_d  = '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    iter_d  = '0;
                    conv_d  = 1'b0;
                    if (num_points == '0 || max_iter == '0) state_d = DONE;
                    else begin
                        np_d    = num_points;
                        mi_d    = max_iter;
                        state_d = CLEAR;
                    end
                end
                CLEAR: begin
                    addr_d  = '0;
                    state_d = STREAM;
                end
                STREAM: begin
                    addr_d  = (addr_q == np_q - PW'(1)) ? '0 : addr_q + PW'(1);
                    state_d = (addr_q == np_q - PW'(1)) ? DRAIN : STREAM;
                end
                DRAIN: state_d = SWAP;
                SWAP:  state_d = LOAD;
                LOAD: begin
                    iter_d  = iter_q + IW'(1);
                    conv_d  = conv_q | converged;
                    state_d = (converged || iter_d == mi_q) ? DONE : CLEAR;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end
    // state registers; acc is the read strobe delayed to line up with returning memory data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            np_q    <= '0;
            mi_q    <= '0;
            iter_q  <= '0;
            conv_q  <= 1'b0;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            np_q    <= np_d;
            mi_q    <= mi_d;
            iter_q  <= iter_d;
            conv_q  <= conv_d;
            acc_q   <= pt_rd && !abort;
        end
    end
    assign pt_rd      = state_q == STREAM;
    assign pt_addr    = pt_rd ? addr_q : '0;
    assign acc_rst    = state_q == CLEAR;
    assign acc        = acc_q;
    assign swap       = state_q == SWAP;
    assign cent_load  = state_q == LOAD;
    assign busy       = state_q != IDLE;
    assign done       = state_q == DONE;
    assign conv_flag  = conv_q;
    assign iter_count = iter_q;
endmodule
